// File: rtl/npc_mem_pkg.sv
// Shared definitions for the data-memory access path: memop encodings,
// access FSM states and store-lane helpers.
package npc_mem_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } mem_state_t;

    // size is memop[1:0]: 00 byte, 01 half, 10 word
    function automatic logic [3:0] gen_wstrb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] gen_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data alignment and sign/zero extension of a bus word.
module load_extend
    import npc_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  memop,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        case (memop)
            MEMOP_B:  result = {{24{shifted[7]}}, shifted[7:0]};
            MEMOP_H:  result = {{16{shifted[15]}}, shifted[15:0]};
            MEMOP_BU: result = {24'h0, shifted[7:0]};
            MEMOP_HU: result = {16'h0, shifted[15:0]};
            default:  result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: validates the core's access, runs it on a
// word-addressed req/gnt/rvalid bus and returns extended data or an error.
module mem_access_unit
    import npc_mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  memop,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] memdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    mem_state_t    state, state_n;
    logic [CW-1:0] cnt;
    logic [2:0]    op_q;
    logic [1:0]    off_q;
    logic          req_bad;
    logic          timed_out;
    logic [31:0]   load_result;

    load_extend u_load_extend (
        .rdata  (bus_rdata),
        .off    (off_q),
        .memop  (op_q),
        .result (load_result)
    );

    // Illegal opcodes, misalignment and unsigned-store encodings never reach the bus
    always_comb begin
        req_bad = 1'b0;
        case (memop)
            MEMOP_B, MEMOP_BU: req_bad = 1'b0;
            MEMOP_H, MEMOP_HU: req_bad = mem_addr[0];
            MEMOP_W:           req_bad = |mem_addr[1:0];
            default:           req_bad = 1'b1;
        endcase
        if (mem_wen && memop[2])
            req_bad = 1'b1;
    end

    assign timed_out  = (cnt == CNT_MAX);
    assign req_ready  = (state == ST_IDLE) && !rst;
    assign bus_req    = (state == ST_REQ);
    assign resp_valid = (state == ST_RESP);

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (req_valid) state_n = req_bad ? ST_RESP : ST_REQ;
            ST_REQ: begin
                if (bus_gnt)        state_n = bus_we ? ST_RESP : ST_WAIT;
                else if (timed_out) state_n = ST_RESP;
            end
            ST_WAIT: if (bus_rvalid || timed_out) state_n = ST_RESP;
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            off_q     <= '0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
            resp_err  <= 1'b0;
            resp_data <= '0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q      <= memop;
                        off_q     <= mem_addr[1:0];
                        cnt       <= '0;
                        resp_err  <= req_bad;
                        resp_data <= '0;
                        if (!req_bad) begin
                            bus_we    <= mem_wen;
                            bus_addr  <= {mem_addr[31:2], 2'b00};
                            bus_wdata <= mem_wen ? gen_wdata(memop[1:0], memdata) : 32'h0;
                            bus_wstrb <= mem_wen ? gen_wstrb(memop[1:0], mem_addr[1:0]) : 4'h0;
                        end
                    end
                end
                ST_REQ: begin
                    cnt <= cnt + CW'(1);
                    if (!bus_gnt && timed_out)
                        resp_err <= 1'b1;
                end
                ST_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (bus_rvalid)
                        resp_data <= load_result;
                    else if (timed_out)
                        resp_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a response scoreboard.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  memop;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] memdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          lat;
    } exp_t;
    exp_t sb[$];

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .memop      (memop),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .memdata    (memdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gnt_dly/rv_dly < 0 means the bus never answers that phase
    task automatic access(input string tag, input logic [2:0] op, input logic wen,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                          input logic exp_err, input logic [31:0] exp_data, input int exp_lat,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        int   cyc;
        bit   done;
        bit   seen;
        exp_t e;
        chk({tag, "_ready_idle"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        memop     = op;
        mem_wen   = wen;
        mem_addr  = addr;
        memdata   = data;
        sb.push_back('{err: exp_err, data: exp_data, lat: exp_lat});
        tick();
        req_valid = 1'b0;
        cyc  = 1;
        done = 0;
        seen = 0;
        chk({tag, "_ready_busy"}, {31'h0, req_ready}, 32'h0);
        while (!done && cyc <= 30) begin
            bus_gnt    = (gnt_dly >= 0) && (cyc == 1 + gnt_dly);
            bus_rvalid = !wen && (gnt_dly >= 0) && (rv_dly >= 0) && (cyc == 2 + gnt_dly + rv_dly);
            bus_rdata  = rdata;
            if (bus_req && !seen) begin
                seen = 1;
                chk({tag, "_bus_addr"}, bus_addr, {addr[31:2], 2'b00});
                chk({tag, "_bus_we"}, {31'h0, bus_we}, {31'h0, wen});
                chk({tag, "_bus_wstrb"}, {28'h0, bus_wstrb}, {28'h0, exp_strb});
                if (wen)
                    chk({tag, "_bus_wdata"}, bus_wdata, exp_wdata);
            end
            if (resp_valid) begin
                done = 1;
                if (sb.size() == 0) begin
                    chk({tag, "_sb_nonempty"}, 32'h0, 32'h1);
                end else begin
                    e = sb.pop_front();
                    chk({tag, "_err"}, {31'h0, resp_err}, {31'h0, e.err});
                    chk({tag, "_data"}, resp_data, e.data);
                    chk({tag, "_latency"}, 32'(cyc), 32'(e.lat));
                end
            end else begin
                tick();
                cyc++;
            end
        end
        chk({tag, "_completed"}, {31'h0, done}, 32'h1);
        chk({tag, "_bus_used"}, {31'h0, seen}, {31'h0, !exp_err || (gnt_dly < 0) || (rv_dly < 0 && !wen)});
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        tick();
        chk({tag, "_pulse_end"}, {31'h0, resp_valid}, 32'h0);
        chk({tag, "_ready_after"}, {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        memop = 3'b000;
        mem_wen = 1'b0;
        mem_addr = 32'h0;
        memdata = 32'h0;
        bus_gnt = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata = 32'h0;
        tick();
        tick();
        chk("rst_ready_low", {31'h0, req_ready}, 32'h0);
        rst = 1'b0;
        tick();
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wstrb", {28'h0, bus_wstrb}, 32'h0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);

        access("lw",  3'b010, 1'b0, 32'h8000_0004, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 3, 4'h0, 32'h0);
        access("lb",  3'b000, 1'b0, 32'h8000_0003, 32'h0, 0, 0, 32'h8011_2233, 1'b0, 32'hFFFF_FF80, 3, 4'h0, 32'h0);
        access("lbu", 3'b100, 1'b0, 32'h8000_0003, 32'h0, 0, 0, 32'h8011_2233, 1'b0, 32'h0000_0080, 3, 4'h0, 32'h0);
        access("lhu", 3'b101, 1'b0, 32'h8000_0002, 32'h0, 0, 0, 32'h8011_2233, 1'b0, 32'h0000_8011, 3, 4'h0, 32'h0);
        access("lh",  3'b001, 1'b0, 32'h8000_0002, 32'h0, 0, 0, 32'h8011_2233, 1'b0, 32'hFFFF_8011, 3, 4'h0, 32'h0);
        access("lb0", 3'b000, 1'b0, 32'h8000_0000, 32'h0, 0, 0, 32'h8011_227F, 1'b0, 32'h0000_007F, 3, 4'h0, 32'h0);
        access("sb",  3'b000, 1'b1, 32'h8000_0001, 32'h0000_00AB, 0, -1, 32'h0, 1'b0, 32'h0, 2, 4'b0010, 32'hABAB_ABAB);
        access("sh",  3'b001, 1'b1, 32'h8000_0002, 32'h0000_1234, 0, -1, 32'h0, 1'b0, 32'h0, 2, 4'b1100, 32'h1234_1234);
        access("sw",  3'b010, 1'b1, 32'h8000_0008, 32'hCAFE_F00D, 1, -1, 32'h0, 1'b0, 32'h0, 3, 4'b1111, 32'hCAFE_F00D);
        access("lw_mis", 3'b010, 1'b0, 32'h8000_0002, 32'h0, 0, 0, 32'h1111_1111, 1'b1, 32'h0, 1, 4'h0, 32'h0);
        access("op011",  3'b011, 1'b0, 32'h8000_0000, 32'h0, 0, 0, 32'h1111_1111, 1'b1, 32'h0, 1, 4'h0, 32'h0);
        access("sbu",    3'b100, 1'b1, 32'h8000_0000, 32'h55, 0, -1, 32'h0, 1'b1, 32'h0, 1, 4'h0, 32'h0);
        access("sw_to",  3'b010, 1'b1, 32'h8000_0010, 32'h1, -1, -1, 32'h0, 1'b1, 32'h0, 6, 4'b1111, 32'h1);
        access("lw_to",  3'b010, 1'b0, 32'h8000_0014, 32'h0, 1, -1, 32'h0, 1'b1, 32'h0, 6, 4'h0, 32'h0);
        access("lw_stall", 3'b010, 1'b0, 32'h8000_0018, 32'h0, 1, 1, 32'h1234_5678, 1'b0, 32'h1234_5678, 5, 4'h0, 32'h0);

        // reset while waiting for read data; the late rvalid must be ignored
        req_valid = 1'b1;
        memop     = 3'b010;
        mem_wen   = 1'b0;
        mem_addr  = 32'h8000_0020;
        tick();
        req_valid = 1'b0;
        bus_gnt   = 1'b1;
        tick();
        bus_gnt = 1'b0;
        rst     = 1'b1;
        tick();
        chk("mrst_bus_req", {31'h0, bus_req}, 32'h0);
        chk("mrst_resp_valid", {31'h0, resp_valid}, 32'h0);
        rst        = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hBAD0_BAD0;
        tick();
        bus_rvalid = 1'b0;
        chk("mrst_late_rvalid", {31'h0, resp_valid}, 32'h0);
        chk("mrst_ready", {31'h0, req_ready}, 32'h1);
        tick();
        chk("mrst_still_quiet", {31'h0, resp_valid}, 32'h0);
        access("lw_post_rst", 3'b010, 1'b0, 32'h8000_0024, 32'h0, 0, 0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 3, 4'h0, 32'h0);

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
